// File: rtl/mat_vec_mul_n.sv
// rtl/mat_vec_mul_n.sv - pipelined fixed-point NxN matrix by N-vector multiplier (y = A*x or A^T*x)
// One column of products is accumulated per stage; the whole pipe stalls on output backpressure.
module mat_vec_mul_n #(
   parameter int DIM       = 4,
   parameter int DATAWIDTH = 18,
   parameter int FRACBITS  = 12,
   parameter int ROUND     = 0,
   parameter int SATURATE  = 1
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        i_valid,
   output logic                        i_ready,
   input  logic                        i_transpose,
   input  logic signed [DATAWIDTH-1:0] A [DIM][DIM],
   input  logic signed [DATAWIDTH-1:0] x [DIM],
   output logic                        o_valid,
   input  logic                        o_ready,
   output logic signed [DATAWIDTH-1:0] y [DIM],
   output logic [DIM-1:0]              o_ovf
);
   localparam int ACCW = 2*DATAWIDTH + $clog2(DIM);

   typedef logic signed [DATAWIDTH-1:0] elem_t;
   typedef logic signed [ACCW-1:0]      acc_t;

   localparam acc_t  YMAX = {{(ACCW-DATAWIDTH+1){1'b0}}, {(DATAWIDTH-1){1'b1}}};
   localparam acc_t  YMIN = ~YMAX;
   localparam elem_t EMAX = {1'b0, {(DATAWIDTH-1){1'b1}}};
   localparam elem_t EMIN = ~EMAX;
   localparam acc_t  RND  = (ROUND != 0 && FRACBITS > 0) ?
                            (acc_t'(1) <<< (FRACBITS > 0 ? FRACBITS-1 : 0)) : '0;

   logic           advance;
   logic [DIM-1:0] s_v;
   logic [DIM-1:0] s_t;
   elem_t          s_a   [DIM][DIM][DIM];
   elem_t          s_x   [DIM][DIM];
   acc_t           s_acc [1:DIM-1][DIM];
   acc_t           sum   [DIM][DIM];
   acc_t           rs    [DIM];
   elem_t          y_nxt [DIM];
   logic [DIM-1:0] ovf_nxt;

   assign advance = ~(o_valid & ~o_ready);
   assign i_ready = advance;

   // Operands are widened before the multiply so the product and sum are exact.
   function automatic acc_t mac(input elem_t a, input elem_t b);
      return acc_t'(a) * acc_t'(b);
   endfunction

   // sum[k] is the accumulator leaving stage k after adding column k.
   always_comb begin
      for (int i = 0; i < DIM; i++)
         sum[0][i] = mac(s_t[0] ? s_a[0][0][i] : s_a[0][i][0], s_x[0][0]);
      for (int k = 1; k < DIM; k++)
         for (int i = 0; i < DIM; i++)
            sum[k][i] = s_acc[k][i] + mac(s_t[k] ? s_a[k][k][i] : s_a[k][i][k], s_x[k][k]);
   end

   always_comb begin
      ovf_nxt = '0;
      for (int i = 0; i < DIM; i++) begin
         rs[i]      = (sum[DIM-1][i] + RND) >>> FRACBITS;
         ovf_nxt[i] = (rs[i] > YMAX) || (rs[i] < YMIN);
         if (ovf_nxt[i] && SATURATE != 0)
            y_nxt[i] = rs[i][ACCW-1] ? EMIN : EMAX;
         else
            y_nxt[i] = rs[i][DATAWIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s_v     <= '0;
         o_valid <= 1'b0;
         o_ovf   <= '0;
         for (int i = 0; i < DIM; i++)
            y[i] <= '0;
      end else if (advance) begin
         s_v     <= {s_v[DIM-2:0], i_valid};
         o_valid <= s_v[DIM-1];
         if (s_v[DIM-1]) begin
            y     <= y_nxt;
            o_ovf <= ovf_nxt;
         end
      end
   end

   // Payload needs no reset: it is only ever observed behind a set valid bit.
   always_ff @(posedge clk) begin
      if (advance) begin
         s_a[0] <= A;
         s_x[0] <= x;
         s_t[0] <= i_transpose;
         for (int k = 1; k < DIM; k++) begin
            s_a[k]   <= s_a[k-1];
            s_x[k]   <= s_x[k-1];
            s_t[k]   <= s_t[k-1];
            s_acc[k] <= sum[k-1];
         end
      end
   end

endmodule

// File: tb/tb_mat_vec_mul_n.sv
// tb/tb_mat_vec_mul_n.sv - randomized and directed self-checking bench for mat_vec_mul_n
module tb_mat_vec_mul_n;
   localparam int N = 4;
   localparam int W = 18;
   localparam int F = 12;
   localparam longint YMAX = (64'sd1 <<< (W-1)) - 1;
   localparam longint YMIN = -YMAX - 1;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic i_valid = 1'b0;
   logic i_transpose = 1'b0;
   logic o_ready = 1'b1;
   logic signed [W-1:0] A [N][N];
   logic signed [W-1:0] x [N];
   logic i_ready0, i_ready1, o_valid0, o_valid1;
   logic signed [W-1:0] y0 [N];
   logic signed [W-1:0] y1 [N];
   logic [N-1:0] ovf0, ovf1;

   int vectors = 0;
   int errs = 0;
   logic rec_en = 1'b0;
   logic signed [W-1:0] seen [$];

   // Reference: a delay line of finished results; entry d holds the (rnd=d, sat=!d) flavour.
   logic          pv [N];
   longint        py [N][2][N];
   logic [N-1:0]  pf [N][2];
   logic          mv;
   longint        my [2][N];
   logic [N-1:0]  mf [2];

   always #5 clk = ~clk;

   mat_vec_mul_n #(.DIM(N), .DATAWIDTH(W), .FRACBITS(F), .ROUND(0), .SATURATE(1)) dut0 (
      .clk(clk), .rstn(rstn), .i_valid(i_valid), .i_ready(i_ready0), .i_transpose(i_transpose),
      .A(A), .x(x), .o_valid(o_valid0), .o_ready(o_ready), .y(y0), .o_ovf(ovf0));

   mat_vec_mul_n #(.DIM(N), .DATAWIDTH(W), .FRACBITS(F), .ROUND(1), .SATURATE(0)) dut1 (
      .clk(clk), .rstn(rstn), .i_valid(i_valid), .i_ready(i_ready1), .i_transpose(i_transpose),
      .A(A), .x(x), .o_valid(o_valid1), .o_ready(o_ready), .y(y1), .o_ovf(ovf1));

   task automatic check(input string name, input logic signed [63:0] got, input logic signed [63:0] exp);
      vectors++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
      end
   endtask

   function automatic longint ref_lane(input int rnd, input int sat, input logic t, input int i,
                                       output logic ovf_b);
      longint acc, r, w;
      acc = 0;
      for (int j = 0; j < N; j++)
         acc += longint'(t ? A[j][i] : A[i][j]) * longint'(x[j]);
      r = (acc + (rnd != 0 ? (64'sd1 <<< (F-1)) : 64'sd0)) >>> F;
      ovf_b = (r > YMAX) || (r < YMIN);
      if (!ovf_b) return r;
      if (sat != 0) return (r < 0) ? YMIN : YMAX;
      w = r & ((64'sd1 <<< W) - 1);
      if (w > YMAX) w -= (64'sd1 <<< W);
      return w;
   endfunction

   task automatic model_clear();
      mv = 1'b0;
      for (int d = 0; d < 2; d++) begin
         mf[d] = '0;
         for (int i = 0; i < N; i++) my[d][i] = 0;
      end
      for (int k = 0; k < N; k++) pv[k] = 1'b0;
   endtask

   initial model_clear();
   always @(negedge rstn) model_clear();

   always @(posedge clk) begin
      logic ovf_b;
      if (rstn && !(mv && !o_ready)) begin
         mv = pv[N-1];
         if (pv[N-1]) begin
            my = py[N-1];
            mf = pf[N-1];
         end
         for (int k = N-1; k > 0; k--) begin
            pv[k] = pv[k-1];
            py[k] = py[k-1];
            pf[k] = pf[k-1];
         end
         pv[0] = i_valid;
         if (i_valid)
            for (int d = 0; d < 2; d++)
               for (int i = 0; i < N; i++) begin
                  py[0][d][i] = ref_lane(d, (d == 0) ? 1 : 0, i_transpose, i, ovf_b);
                  pf[0][d][i] = ovf_b;
               end
      end
   end

   always @(negedge clk) begin
      if (rstn) begin
         check("o_valid0", o_valid0, mv);
         check("o_valid1", o_valid1, mv);
         check("i_ready0", i_ready0, !(mv && !o_ready));
         check("i_ready1", i_ready1, !(mv && !o_ready));
         check("o_ovf0", ovf0, mf[0]);
         check("o_ovf1", ovf1, mf[1]);
         for (int i = 0; i < N; i++) begin
            check($sformatf("y0[%0d]", i), y0[i], my[0][i]);
            check($sformatf("y1[%0d]", i), y1[i], my[1][i]);
         end
      end
   end

   always @(negedge clk) begin
      #2;
      if (rec_en && o_valid0 && o_ready) seen.push_back(y0[0]);
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_ax();
      for (int r = 0; r < N; r++) begin
         x[r] = '0;
         for (int c = 0; c < N; c++) A[r][c] = '0;
      end
   endtask

   task automatic send_tx(input logic t);
      int n = 0;
      i_valid = 1'b1;
      i_transpose = t;
      #1;
      while (!i_ready0 && n < 50) begin
         tick();
         #1;
         n++;
      end
      if (!i_ready0) begin
         vectors++; errs++;
         $display("FAIL send_tx i_ready got=0 exp=1 (timeout)");
      end
      tick();
      i_valid = 1'b0;
   endtask

   task automatic wait_out(input string name);
      int n = 0;
      while (!o_valid0 && n < 30) begin
         tick();
         n++;
      end
      if (!o_valid0) begin
         vectors++; errs++;
         $display("FAIL %s o_valid got=0 exp=1 (timeout)", name);
      end
   endtask

   function automatic logic signed [W-1:0] rnd_el(input logic big);
      logic signed [W-1:0] v;
      if (big) return W'($urandom);
      v = W'($urandom_range(0, 16383));
      return v - 18'sd8192;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      int n;
      int nv;
      logic ob;
      clear_ax();
      tick();
      check("rst_o_valid", o_valid0, 0);
      check("rst_y0", y0[0], 0);
      check("rst_ovf", ovf0, 0);
      check("rst_i_ready", i_ready0, 1);
      rstn = 1'b1;

      // identity, exact latency
      for (int i = 0; i < N; i++) A[i][i] = 18'sd4096;
      x[0] = 18'sd4096; x[1] = 18'sd8192; x[2] = -18'sd4096; x[3] = 18'sd2048;
      check("pin_ident", ref_lane(0, 1, 1'b0, 2, ob), -4096);
      send_tx(1'b0);
      n = 0;
      while (!o_valid0 && n < 20) begin tick(); n++; end
      check("latency", n, N);
      check("ident_y0", y0[0], 4096);
      check("ident_y1", y0[1], 8192);
      check("ident_y2", y0[2], -4096);
      check("ident_y3", y0[3], 2048);
      check("ident_ovf", ovf0, 0);

      // saturation vs wrap
      clear_ax();
      for (int i = 0; i < N; i++) begin A[i][i] = 18'sd131071; x[i] = 18'sd131071; end
      check("pin_sat", ref_lane(0, 1, 1'b0, 0, ob), 131071);
      check("pin_wrap", ref_lane(1, 0, 1'b0, 0, ob), -64);
      send_tx(1'b0);
      wait_out("sat");
      for (int i = 0; i < N; i++) begin
         check("sat_y", y0[i], 131071);
         check("wrap_y", y1[i], -64);
      end
      check("sat_ovf", ovf0, 4'hf);
      check("wrap_ovf", ovf1, 4'hf);

      // rounding
      clear_ax();
      A[0][0] = 18'sd1; x[0] = 18'sd2048;
      check("pin_trunc_pos", ref_lane(0, 1, 1'b0, 0, ob), 0);
      check("pin_round_pos", ref_lane(1, 0, 1'b0, 0, ob), 1);
      send_tx(1'b0);
      wait_out("round_pos");
      check("trunc_pos", y0[0], 0);
      check("round_pos", y1[0], 1);
      A[0][0] = -18'sd1;
      check("pin_trunc_neg", ref_lane(0, 1, 1'b0, 0, ob), -1);
      send_tx(1'b0);
      wait_out("round_neg");
      check("trunc_neg", y0[0], -1);
      check("round_neg", y1[0], 0);
      check("round_ovf", ovf0, 0);

      // transpose, back-to-back with no mode leakage
      clear_ax();
      A[0][1] = 18'sd4096; x[0] = 18'sd4096;
      send_tx(1'b0);
      send_tx(1'b1);
      wait_out("transpose");
      for (int i = 0; i < N; i++) check("normal_y", y0[i], 0);
      tick();
      check("tr_valid", o_valid0, 1);
      check("tr_y0", y0[0], 0);
      check("tr_y1", y0[1], 4096);
      check("tr_y2", y0[2], 0);
      check("tr_y3", y0[3], 0);
      tick();

      // stall: six back-to-back, o_ready low for three cycles once output appears
      clear_ax();
      for (int i = 0; i < N; i++) A[i][i] = 18'sd4096;
      seen.delete();
      rec_en = 1'b1;
      fork
         begin
            for (int k = 1; k <= 6; k++) begin
               x[0] = 18'(k * 4096);
               send_tx(1'b0);
            end
         end
         begin
            int k = 0;
            while (!o_valid0 && k < 40) begin @(negedge clk); k++; end
            #1 o_ready = 1'b0;
            repeat (3) begin
               #1;
               check("stall_i_ready", i_ready0, 0);
               check("stall_y_hold", y0[0], 4096);
               tick();
            end
            o_ready = 1'b1;
         end
      join
      repeat (12) tick();
      rec_en = 1'b0;
      check("stall_count", seen.size(), 6);
      for (int k = 0; k < seen.size() && k < 6; k++)
         check("stall_order", seen[k], (k + 1) * 4096);

      // randomized traffic with random backpressure
      for (int c = 0; c < 400; c++) begin
         logic big;
         o_ready = ($urandom_range(0, 3) != 0);
         i_valid = ($urandom_range(0, 3) != 0);
         i_transpose = 1'($urandom_range(0, 1));
         big = 1'($urandom_range(0, 1));
         for (int r = 0; r < N; r++) begin
            x[r] = rnd_el(big);
            for (int cc = 0; cc < N; cc++) A[r][cc] = rnd_el(big);
         end
         tick();
      end
      i_valid = 1'b0;
      o_ready = 1'b1;
      repeat (10) tick();

      // asynchronous reset with transactions in flight
      send_tx(1'b0);
      send_tx(1'b1);
      send_tx(1'b0);
      rstn = 1'b0;
      #1;
      check("arst_o_valid0", o_valid0, 0);
      check("arst_o_valid1", o_valid1, 0);
      check("arst_ovf0", ovf0, 0);
      check("arst_ovf1", ovf1, 0);
      for (int i = 0; i < N; i++) begin
         check("arst_y0", y0[i], 0);
         check("arst_y1", y1[i], 0);
      end
      #2 rstn = 1'b1;
      nv = 0;
      repeat (8) begin
         @(negedge clk);
         if (o_valid0 || o_valid1) nv++;
      end
      check("post_reset_valid", nv, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
